// File: rtl/fruit_bbox_detect.sv
// Raster-scan bounding box of the binary fruit mask, published once per frame on rising vsync.
// Latency: results and the frame_done pulse appear two edges after vsync is first sampled high; no backpressure.
module fruit_bbox_detect #(
   parameter logic [11:0] IMG_WIDTH       = 12'd640,
   parameter logic [11:0] IMG_HEIGHT      = 12'd480,
   parameter logic [19:0] MIN_PIXELS      = 20'd500,
   parameter logic [11:0] MIN_SIZE        = 12'd8,
   parameter logic [11:0] LABEL_CLEARANCE = 12'd28,
   parameter logic [3:0]  HOLD_FRAMES     = 4'd2
) (
   input  logic        pixelclk,
   input  logic        reset,
   input  logic        i_vsync,
   input  logic        i_de,
   input  logic        i_mask,
   input  logic [11:0] hcount,
   input  logic [11:0] vcount,
   output logic [11:0] hcount_l1,
   output logic [11:0] hcount_r1,
   output logic [11:0] vcount_l1,
   output logic [11:0] vcount_r1,
   output logic        en,
   output logic [19:0] pixel_count,
   output logic        frame_done
);

   // stage 0 input registers
   logic        de_q, de_d;
   logic        mask_q, mask_d;
   logic [11:0] hc_q, hc_d;
   logic [11:0] vc_q, vc_d;
   logic        vs_d0_q, vs_d0_d;
   logic        vs_d1_q, vs_d1_d;
   logic        armed_q, armed_d;

   // per-frame accumulators
   logic [11:0] min_x_q, min_x_d;
   logic [11:0] max_x_q, max_x_d;
   logic [11:0] min_y_q, min_y_d;
   logic [11:0] max_y_q, max_y_d;
   logic [19:0] cnt_q, cnt_d;

   // published results
   logic [11:0] hcount_l1_q, hcount_l1_d;
   logic [11:0] hcount_r1_q, hcount_r1_d;
   logic [11:0] vcount_l1_q, vcount_l1_d;
   logic [11:0] vcount_r1_q, vcount_r1_d;
   logic [19:0] pixel_count_q, pixel_count_d;
   logic        en_q, en_d;
   logic        frame_done_q, frame_done_d;
   logic [3:0]  miss_cnt_q, miss_cnt_d;

   logic        qual;
   logic        frame_end;
   logic [12:0] box_w;
   logic [12:0] box_h;
   logic        frame_valid;
   logic [3:0]  miss_next;

   assign qual = de_q & mask_q & (hc_q < IMG_WIDTH) & (vc_q < IMG_HEIGHT);

   // armed_q blocks a vsync that was already high out of reset from looking like a rising edge
   assign frame_end = vs_d0_q & ~vs_d1_q & armed_q;

   assign box_w = {1'b0, max_x_q} - {1'b0, min_x_q} + 13'd1;
   assign box_h = {1'b0, max_y_q} - {1'b0, min_y_q} + 13'd1;

   assign frame_valid = (cnt_q != 20'd0) && (cnt_q >= MIN_PIXELS) &&
                        (box_w >= {1'b0, MIN_SIZE}) && (box_h >= {1'b0, MIN_SIZE});

   assign miss_next = (miss_cnt_q >= HOLD_FRAMES) ? HOLD_FRAMES : miss_cnt_q + 4'd1;

   always_comb begin
      de_d          = i_de;
      mask_d        = i_mask;
      hc_d          = hcount;
      vc_d          = vcount;
      vs_d0_d       = i_vsync;
      vs_d1_d       = vs_d0_q;
      armed_d       = armed_q | ~i_vsync;
      min_x_d       = min_x_q;
      max_x_d       = max_x_q;
      min_y_d       = min_y_q;
      max_y_d       = max_y_q;
      cnt_d         = cnt_q;
      hcount_l1_d   = hcount_l1_q;
      hcount_r1_d   = hcount_r1_q;
      vcount_l1_d   = vcount_l1_q;
      vcount_r1_d   = vcount_r1_q;
      pixel_count_d = pixel_count_q;
      en_d          = en_q;
      frame_done_d  = 1'b0;
      miss_cnt_d    = miss_cnt_q;

      if (frame_end) begin
         // a pixel coinciding with the frame boundary belongs to the new frame
         if (qual) begin
            min_x_d = hc_q;
            max_x_d = hc_q;
            min_y_d = vc_q;
            max_y_d = vc_q;
            cnt_d   = 20'd1;
         end else begin
            min_x_d = 12'hFFF;
            max_x_d = 12'd0;
            min_y_d = 12'hFFF;
            max_y_d = 12'd0;
            cnt_d   = 20'd0;
         end
      end else if (qual) begin
         if (hc_q < min_x_q) min_x_d = hc_q;
         if (hc_q > max_x_q) max_x_d = hc_q;
         if (vc_q < min_y_q) min_y_d = vc_q;
         if (vc_q > max_y_q) max_y_d = vc_q;
         if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
      end

      if (frame_end) begin
         frame_done_d  = 1'b1;
         pixel_count_d = cnt_q;
         if (frame_valid) begin
            hcount_l1_d = min_x_q;
            hcount_r1_d = max_x_q;
            vcount_l1_d = (min_y_q < LABEL_CLEARANCE) ? LABEL_CLEARANCE : min_y_q;
            vcount_r1_d = max_y_q;
            en_d        = 1'b1;
            miss_cnt_d  = 4'd0;
         end else begin
            miss_cnt_d = miss_next;
            if (miss_next >= HOLD_FRAMES) en_d = 1'b0;
         end
      end
   end

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         de_q          <= 1'b0;
         mask_q        <= 1'b0;
         hc_q          <= 12'd0;
         vc_q          <= 12'd0;
         vs_d0_q       <= 1'b0;
         vs_d1_q       <= 1'b0;
         armed_q       <= 1'b0;
         min_x_q       <= 12'hFFF;
         max_x_q       <= 12'd0;
         min_y_q       <= 12'hFFF;
         max_y_q       <= 12'd0;
         cnt_q         <= 20'd0;
         hcount_l1_q   <= 12'd0;
         hcount_r1_q   <= 12'd0;
         vcount_l1_q   <= 12'd0;
         vcount_r1_q   <= 12'd0;
         pixel_count_q <= 20'd0;
         en_q          <= 1'b0;
         frame_done_q  <= 1'b0;
         miss_cnt_q    <= 4'd0;
      end else begin
         de_q          <= de_d;
         mask_q        <= mask_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         vs_d0_q       <= vs_d0_d;
         vs_d1_q       <= vs_d1_d;
         armed_q       <= armed_d;
         min_x_q       <= min_x_d;
         max_x_q       <= max_x_d;
         min_y_q       <= min_y_d;
         max_y_q       <= max_y_d;
         cnt_q         <= cnt_d;
         hcount_l1_q   <= hcount_l1_d;
         hcount_r1_q   <= hcount_r1_d;
         vcount_l1_q   <= vcount_l1_d;
         vcount_r1_q   <= vcount_r1_d;
         pixel_count_q <= pixel_count_d;
         en_q          <= en_d;
         frame_done_q  <= frame_done_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   assign hcount_l1   = hcount_l1_q;
   assign hcount_r1   = hcount_r1_q;
   assign vcount_l1   = vcount_l1_q;
   assign vcount_r1   = vcount_r1_q;
   assign pixel_count = pixel_count_q;
   assign en          = en_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_fruit_bbox_detect.sv
// Directed bench for fruit_bbox_detect; observed outputs packed as {l1,r1,vl1,vr1,pixel_count,en,frame_done}.
module tb_fruit_bbox_detect;

   logic        pixelclk;
   logic        reset;
   logic        i_vsync;
   logic        i_de;
   logic        i_mask;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic [11:0] hcount_l1;
   logic [11:0] hcount_r1;
   logic [11:0] vcount_l1;
   logic [11:0] vcount_r1;
   logic        en;
   logic [19:0] pixel_count;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   fruit_bbox_detect dut (
      .pixelclk    (pixelclk),
      .reset       (reset),
      .i_vsync     (i_vsync),
      .i_de        (i_de),
      .i_mask      (i_mask),
      .hcount      (hcount),
      .vcount      (vcount),
      .hcount_l1   (hcount_l1),
      .hcount_r1   (hcount_r1),
      .vcount_l1   (vcount_l1),
      .vcount_r1   (vcount_r1),
      .en          (en),
      .pixel_count (pixel_count),
      .frame_done  (frame_done)
   );

   initial pixelclk = 1'b0;
   always #5 pixelclk = ~pixelclk;

   function automatic logic [69:0] obs_now();
      return {hcount_l1, hcount_r1, vcount_l1, vcount_r1, pixel_count, en, frame_done};
   endfunction

   task automatic drive_rect(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++) begin
         for (int x = x0; x <= x1; x++) begin
            @(negedge pixelclk);
            i_de   = 1'b1;
            i_mask = 1'b1;
            hcount = 12'(x);
            vcount = 12'(y);
         end
      end
      @(negedge pixelclk);
      i_de   = 1'b0;
      i_mask = 1'b0;
   endtask

   // raise vsync (optionally with a foreground pixel in the same cycle) and sample after edges 1, 2, 3
   task automatic end_frame(input bit seed, input logic [11:0] sx, input logic [11:0] sy,
                            output logic fd_e1, output logic [69:0] obs_e2, output logic fd_e3);
      @(negedge pixelclk);
      i_vsync = 1'b1;
      i_de    = seed;
      i_mask  = seed;
      hcount  = sx;
      vcount  = sy;
      @(posedge pixelclk); #1;
      fd_e1  = frame_done;
      i_de   = 1'b0;
      i_mask = 1'b0;
      @(posedge pixelclk); #1;
      obs_e2 = obs_now();
      @(posedge pixelclk); #1;
      fd_e3 = frame_done;
      @(negedge pixelclk);
      i_vsync = 1'b0;
      repeat (3) @(negedge pixelclk);
   endtask

   task automatic test_reset();
      logic fd_seen;
      reset   = 1'b1;
      i_vsync = 1'b1;
      i_de    = 1'b1;
      i_mask  = 1'b1;
      hcount  = 12'd10;
      vcount  = 12'd10;
      repeat (5) @(posedge pixelclk);
      #1;
      checks++;
      if (obs_now() !== 70'd0) begin
         failures++;
         $display("FAIL reset_state obs=%h exp=%h", obs_now(), 70'd0);
      end
      @(negedge pixelclk);
      reset  = 1'b0;
      i_de   = 1'b0;
      i_mask = 1'b0;
      fd_seen = 1'b0;
      repeat (4) begin
         @(posedge pixelclk); #1;
         fd_seen = fd_seen | frame_done;
      end
      checks++;
      if (fd_seen !== 1'b0) begin
         failures++;
         $display("FAIL vsync_high_at_release frame_done_seen=%b exp=0", fd_seen);
      end
      checks++;
      if (obs_now() !== 70'd0) begin
         failures++;
         $display("FAIL post_release_state obs=%h exp=%h", obs_now(), 70'd0);
      end
      @(negedge pixelclk);
      i_vsync = 1'b0;
      repeat (3) @(negedge pixelclk);
   endtask

   task automatic test_valid_box();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(100, 139, 200, 229);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd100, 12'd139, 12'd200, 12'd229, 20'd1200, 1'b1, 1'b1};
      checks++;
      if (fd1 !== 1'b0) begin
         failures++;
         $display("FAIL latency_edge1 frame_done=%b exp=0", fd1);
      end
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL valid_box obs=%h exp=%h", o, exp_o);
      end
      checks++;
      if (fd3 !== 1'b0) begin
         failures++;
         $display("FAIL pulse_width frame_done=%b exp=0", fd3);
      end
   endtask

   task automatic test_hold();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(100, 119, 200, 223);
      drive_rect(100, 118, 224, 224);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd100, 12'd139, 12'd200, 12'd229, 20'd499, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL hold_first_miss obs=%h exp=%h", o, exp_o);
      end
      drive_rect(100, 119, 200, 223);
      drive_rect(100, 118, 224, 224);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd100, 12'd139, 12'd200, 12'd229, 20'd499, 1'b0, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL hold_second_miss obs=%h exp=%h", o, exp_o);
      end
   endtask

   task automatic test_clearance();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(50, 99, 10, 59);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd50, 12'd99, 12'd28, 12'd59, 20'd2500, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL label_clearance obs=%h exp=%h", o, exp_o);
      end
      checks++;
      if (fd1 !== 1'b0 || fd3 !== 1'b0) begin
         failures++;
         $display("FAIL clearance_pulse e1=%b e3=%b exp=0/0", fd1, fd3);
      end
   endtask

   task automatic test_thin_and_offimage();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(100, 299, 300, 303);
      drive_rect(700, 709, 300, 300);
      drive_rect(10, 19, 480, 480);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd50, 12'd99, 12'd28, 12'd59, 20'd800, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL thin_line obs=%h exp=%h", o, exp_o);
      end
      drive_rect(700, 719, 100, 129);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd50, 12'd99, 12'd28, 12'd59, 20'd0, 1'b0, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL off_image obs=%h exp=%h", o, exp_o);
      end
   endtask

   task automatic test_mid_frame_reset();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(100, 119, 250, 299);
      @(negedge pixelclk);
      vcount = 12'd300;
      reset  = 1'b1;
      @(negedge pixelclk);
      reset = 1'b0;
      #1;
      checks++;
      if (obs_now() !== 70'd0) begin
         failures++;
         $display("FAIL mid_reset_state obs=%h exp=%h", obs_now(), 70'd0);
      end
      drive_rect(100, 119, 301, 350);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd100, 12'd119, 12'd301, 12'd350, 20'd1000, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL mid_reset_frame obs=%h exp=%h", o, exp_o);
      end
   endtask

   task automatic test_back_to_back();
      logic fd1, fd3;
      logic [69:0] o;
      logic [69:0] exp_o;
      drive_rect(200, 219, 100, 124);
      end_frame(1'b1, 12'd5, 12'd460, fd1, o, fd3);
      exp_o = {12'd200, 12'd219, 12'd100, 12'd124, 20'd500, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL coincide_excluded obs=%h exp=%h", o, exp_o);
      end
      drive_rect(200, 219, 100, 124);
      end_frame(1'b0, 12'd0, 12'd0, fd1, o, fd3);
      exp_o = {12'd5, 12'd219, 12'd100, 12'd460, 20'd501, 1'b1, 1'b1};
      checks++;
      if (o !== exp_o) begin
         failures++;
         $display("FAIL coincide_seeded obs=%h exp=%h", o, exp_o);
      end
   endtask

   initial begin
      reset   = 1'b1;
      i_vsync = 1'b0;
      i_de    = 1'b0;
      i_mask  = 1'b0;
      hcount  = 12'd0;
      vcount  = 12'd0;
      test_reset();
      test_valid_box();
      test_hold();
      test_clearance();
      test_thin_and_offimage();
      test_mid_frame_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fruit_bbox_detect.md
Name: fruit_bbox_detect

Overview:
Upstream stage of the per-frame label/box overlay. It scans the binary fruit mask in raster order and tracks the minimum and maximum column and row of foreground pixels. On each frame boundary it publishes the bounding box (hcount_l1/r1, vcount_l1/r1), the foreground pixel count and a box-valid enable `en`. The downstream OSD region generator consumes these outputs directly.

Parameters:
IMG_WIDTH, 12'd640, active columns; pixels with hcount >= IMG_WIDTH are ignored
IMG_HEIGHT, 12'd480, active rows; pixels with vcount >= IMG_HEIGHT are ignored
MIN_PIXELS, 20'd500, minimum foreground count for a valid box
MIN_SIZE, 12'd8, minimum box width and height in pixels
LABEL_CLEARANCE, 12'd28, minimum published top row (room for the label above the box)
HOLD_FRAMES, 4'd2, consecutive invalid frames needed before en drops (anti-flicker)

Ports:
pixelclk  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
i_vsync  in  1  vertical sync, active-high
i_de  in  1  data enable (active video)
i_mask  in  1  binarised fruit mask pixel, 1 = foreground
hcount  in  12  column of current pixel
vcount  in  12  row of current pixel
hcount_l1  out  12  box left column
hcount_r1  out  12  box right column
vcount_l1  out  12  box top row (clamped, see below)
vcount_r1  out  12  box bottom row
en  out  1  box valid / overlay enable
pixel_count  out  20  foreground count of last completed frame
frame_done  out  1  one-cycle pulse when outputs update

Behaviour:
- Stage 0: register i_de, i_mask, hcount, vcount and i_vsync (vs_d0). Register vs_d1 <= vs_d0.
- Qualifying pixel (stage-0 regs): de & mask & hcount < IMG_WIDTH & vcount < IMG_HEIGHT.
- Accumulators: min_x and min_y initialise to 12'hFFF; max_x and max_y initialise to 0; cnt initialises to 0. Each qualifying pixel updates min/max with unsigned compares and increments cnt. cnt saturates at 20'hFFFFF.
- Frame end = vs_d0 & ~vs_d1 (rising vsync). On that edge:
  - latch the results;
  - reinitialise the accumulators;
  - frame_done <= 1 for exactly one cycle.
- Latency: outputs and frame_done change at the second pixelclk edge after i_vsync is first sampled high.
- Simultaneous event: if a qualifying pixel coincides with frame end, that pixel seeds the new frame's accumulators (min = max = its coordinate, cnt = 1). It is not counted in the latched frame.
- Valid frame: cnt >= MIN_PIXELS, (max_x - min_x + 1) >= MIN_SIZE and (max_y - min_y + 1) >= MIN_SIZE. Widths are computed at 13 bits. A frame with no pixels is always invalid.
- Valid frame outputs:
  - coordinates <= min/max values;
  - vcount_l1 <= max(min_y, LABEL_CLEARANCE);
  - en <= 1;
  - miss_cnt <= 0.
- Invalid frame outputs:
  - coordinates hold their previous values;
  - miss_cnt increments, saturating at HOLD_FRAMES;
  - en <= 0 once miss_cnt reaches HOLD_FRAMES, otherwise en is unchanged.
- pixel_count <= cnt on every frame end, valid or not.
- Reset values:
  - all coordinate outputs, pixel_count, frame_done and en = 0; miss_cnt = 0;
  - accumulators at their init values; vs_d0 and vs_d1 = 0.
- Reset mid-frame discards partial accumulation. A vsync already high when reset releases does not produce a frame end until it is seen to rise.
- Outputs are stable between frame_done pulses.

Test Plan:
1. Hold reset for 5 cycles, with mask = 1 and de = 1 -> all outputs 0, en = 0, no frame_done.
2. Drive one frame with a solid rectangle x 100..139, y 200..229 (1200 px), then raise vsync -> two edges later hcount_l1 = 100, hcount_r1 = 139, vcount_l1 = 200, vcount_r1 = 229, pixel_count = 1200, en = 1, frame_done high for 1 cycle.
3. After test 2, drive a frame of 499 px (invalid) -> en stays 1 and coordinates hold. A second 499 px frame -> en = 0, pixel_count = 499, coordinates still 100/139/200/229.
4. Drive a valid rectangle x 50..99, y 10..59 -> vcount_l1 = 28 (clamped), vcount_r1 = 59, en = 1.
5. Drive a 200x4 line (800 px, height 4 < MIN_SIZE), and separately drive mask pixels at hcount = 700 -> in both cases the frame is invalid and off-image pixels are not counted.
6. Assert reset for 1 cycle at row 300 of a frame containing rectangle rows 250..350, then release -> next frame end reports vcount_l1 = 301 or later, and pixel_count covers only post-reset rows. Add a case where a mask pixel coincides with the vsync rise -> it appears in the following frame's result.
